// File: rtl/axi4_mem_responder_if.sv
// ---------------------------------------------------------------------------
// axi4_mem_responder_if
// AXI4 full bus bundle between the Rocket core's 64-bit master port and
// axi4_mem_responder. Clock and reset are not part of the bundle.
//
// Signal summary (direction seen from the slave):
//   AW : awid, awaddr, awlen, awburst, awvalid (in)   awready (out)
//   W  : wdata, wstrb, wlast, wvalid (in)             wready  (out)
//   B  : bready (in)                                  bid, bresp, bvalid (out)
//   AR : arid, araddr, arlen, arburst, arvalid (in)   arready (out)
//   R  : rready (in)                                  rid, rdata, rresp, rlast, rvalid (out)
// ---------------------------------------------------------------------------
interface axi4_mem_responder_if #(
  parameter int C_S_AXI_ID_WIDTH   = 5,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ID_WIDTH-1:0]     awid;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                      awlen;
  logic [1:0]                      awburst;
  logic                            awvalid;
  logic                            awready;

  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wlast;
  logic                            wvalid;
  logic                            wready;

  logic [C_S_AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;

  logic [C_S_AXI_ID_WIDTH-1:0]     arid;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                      arlen;
  logic [1:0]                      arburst;
  logic                            arvalid;
  logic                            arready;

  logic [C_S_AXI_ID_WIDTH-1:0]     rid;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rlast;
  logic                            rvalid;
  logic                            rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// ---------------------------------------------------------------------------
// axi4_mem_responder
// AXI4 full slave backed by a single-port synchronous RAM (one beat per
// word). Serves one read or write burst at a time; used as boot/scratch
// memory for the Rocket core.
//
// Ports:
//   s_axi_aclk     clock
//   s_axi_aresetn  asynchronous active-low reset (aborts any burst in flight)
//   s_axi          AXI4 slave bundle (axi4_mem_responder_if.slave)
//
// Burst handling: FIXED keeps the word index, INCR steps it by one and
// wraps at the RAM end, WRAP and the reserved encoding step like INCR but
// are answered with SLVERR (writes are then suppressed).
// ---------------------------------------------------------------------------
module axi4_mem_responder #(
  parameter int C_S_AXI_ID_WIDTH   = 5,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_WORDS_LOG2   = 12
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi4_mem_responder_if.slave   s_axi
);

  localparam int ID_W   = C_S_AXI_ID_WIDTH;
  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = C_MEM_WORDS_LOG2;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t                state;
  logic                  prio_w;
  logic [ID_W-1:0]       id_q;
  logic [IDX_W-1:0]      idx_q;     // word index of the beat being served
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic                  fixed_q;
  logic                  err_q;

  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_W-1:0]       bid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [ID_W-1:0]       rid_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  idle;
  logic                  conflict;
  logic                  aw_go;
  logic                  ar_go;
  logic                  w_hs;
  logic                  w_final;
  logic                  w_bad;
  logic                  w_err;
  logic                  mem_we;
  logic                  r_adv;
  logic                  rd_en;
  logic [IDX_W-1:0]      next_idx;
  logic [IDX_W-1:0]      rd_idx;

  // Address bits outside the word index are deliberately ignored.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+3], s_axi.awaddr[2:0],
                              s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+3], s_axi.araddr[2:0]};

  // Ready is gated by reset so that every output reads 0 while reset is held.
  assign idle     = (state == IDLE) && s_axi_aresetn;
  assign conflict = s_axi.awvalid && s_axi.arvalid;
  assign aw_go    = idle && s_axi.awvalid && (!s_axi.arvalid || prio_w);
  assign ar_go    = idle && s_axi.arvalid && (!s_axi.awvalid || !prio_w);

  assign w_hs     = wready_q && s_axi.wvalid;
  assign w_final  = (beat_q == len_q);
  // A misplaced or missing wlast poisons this beat and everything after it.
  assign w_bad    = (s_axi.wlast != w_final);
  assign w_err    = err_q || w_bad;
  assign mem_we   = w_hs && !w_err;

  assign next_idx = fixed_q ? idx_q : idx_q + 1'b1;
  // The next beat is fetched in the cycle the current one is accepted, so a
  // held rready leaves the output register untouched.
  assign r_adv    = rvalid_q && s_axi.rready && !rlast_q;
  assign rd_en    = (state == RADDR) || r_adv;
  assign rd_idx   = (state == RADDR) ? idx_q : next_idx;

  assign s_axi.awready = aw_go;
  assign s_axi.arready = ar_go;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

  // RAM array: byte-enabled write port, contents never reset.
  always_ff @(posedge s_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // RAM output register doubles as the R-channel data register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state    <= IDLE;
      prio_w   <= 1'b0;
      id_q     <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      // Alternate the winner only when both channels actually competed.
      if (idle && conflict) prio_w <= !prio_w;

      case (state)
        IDLE: begin
          if (aw_go) begin
            id_q     <= s_axi.awid;
            idx_q    <= s_axi.awaddr[IDX_W+2:3];
            len_q    <= s_axi.awlen;
            beat_q   <= '0;
            fixed_q  <= (s_axi.awburst == BURST_FIXED);
            err_q    <= s_axi.awburst[1];
            wready_q <= 1'b1;
            state    <= WDATA;
          end else if (ar_go) begin
            rid_q    <= s_axi.arid;
            idx_q    <= s_axi.araddr[IDX_W+2:3];
            len_q    <= s_axi.arlen;
            beat_q   <= '0;
            fixed_q  <= (s_axi.arburst == BURST_FIXED);
            err_q    <= s_axi.arburst[1];
            state    <= RADDR;
          end
        end

        WDATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            idx_q  <= next_idx;
            if (w_bad) err_q <= 1'b1;
            if (w_final) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= w_err ? RESP_SLVERR : RESP_OKAY;
              state    <= WRESP;
            end
          end
        end

        WRESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end

        RADDR: begin
          rvalid_q <= 1'b1;
          rlast_q  <= (len_q == 8'd0);
          rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
          state    <= RDATA;
        end

        RDATA: begin
          if (rvalid_q && s_axi.rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state    <= IDLE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              idx_q   <= next_idx;
              rlast_q <= ((beat_q + 8'd1) == len_q);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi4_mem_responder
// Table of directed write/read-back transactions, hand sequences for
// arbitration, rready stalls, wlast errors and mid-burst reset, followed by
// randomized bursts checked against a word-array memory model.
// ---------------------------------------------------------------------------
module tb_axi4_mem_responder;

  localparam int NWORDS = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_mem_responder_if #(.C_S_AXI_ID_WIDTH(5), .C_S_AXI_DATA_WIDTH(64),
                          .C_S_AXI_ADDR_WIDTH(32)) bus ();

  axi4_mem_responder #(.C_S_AXI_ID_WIDTH(5), .C_S_AXI_DATA_WIDTH(64),
                       .C_S_AXI_ADDR_WIDTH(32), .C_MEM_WORDS_LOG2(12)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_mem [NWORDS];
  bit          known   [NWORDS];
  logic [63:0] wbuf    [256];

  typedef struct {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] pat;
    logic [1:0]  exp_resp;
    logic [1:0]  rd_burst;
    logic [7:0]  rd_len;
    int          stall;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: the effect of a whole write burst on a plain word array.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input logic [7:0] strb);
    int base = int'(addr[14:3]);
    if (burst[1]) return 2'b10;
    for (int k = 0; k <= int'(len); k++) begin
      int idx = (burst == 2'b00) ? base : (base + k) % NWORDS;
      for (int b = 0; b < 8; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = wbuf[k][8*b +: 8];
      known[idx] = known[idx] | (strb == 8'hFF);
    end
    return 2'b00;
  endfunction

  // Tasks start and end 1 time unit after a rising edge; outputs are sampled
  // on falling edges.
  task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input int bad,
                          output logic [1:0] resp);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    chk("awready", bus.awready, 1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb;
      bus.wlast = (i == int'(len)) ^ (i == bad);
      bus.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      chk("wready", bus.wready, 1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    chk("bvalid latency", bus.bvalid, 1);
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bid", bus.bid, id);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                         input bit rnd, output logic [63:0] first);
    int n;
    int base = int'(addr[14:3]);
    logic [63:0] hold_d;
    logic        hold_l;
    first = '0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    chk("arready", bus.arready, 1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid early", bus.rvalid, 0);
    for (int k = 0; k <= int'(len); k++) begin
      int idx = (burst == 2'b00) ? base : (base + k) % NWORDS;
      @(negedge clk);
      chk("rvalid", bus.rvalid, 1);
      chk("rid", bus.rid, id);
      chk("rresp", bus.rresp, burst[1] ? 2'b10 : 2'b00);
      chk("rlast", bus.rlast, k == int'(len));
      if (known[idx]) chk("rdata", bus.rdata, ref_mem[idx]);
      if (k == 0) first = bus.rdata;
      n = (k == stall_beat) ? stall_cyc : (rnd ? int'($urandom_range(0, 2)) : 0);
      hold_d = bus.rdata; hold_l = bus.rlast;
      repeat (n) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold rvalid", bus.rvalid, 1);
        chk("hold rdata", bus.rdata, hold_d);
        chk("hold rlast", bus.rlast, hold_l);
      end
      bus.rready = 1'b1;
      @(posedge clk); #1 bus.rready = 1'b0;
    end
    @(negedge clk);
    chk("rvalid after last", bus.rvalid, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " awready"}, bus.awready, 0);
    chk({tag, " arready"}, bus.arready, 0);
    chk({tag, " wready"},  bus.wready, 0);
    chk({tag, " bvalid"},  bus.bvalid, 0);
    chk({tag, " bid"},     bus.bid, 0);
    chk({tag, " bresp"},   bus.bresp, 0);
    chk({tag, " rvalid"},  bus.rvalid, 0);
    chk({tag, " rid"},     bus.rid, 0);
    chk({tag, " rdata"},   bus.rdata, 0);
    chk({tag, " rresp"},   bus.rresp, 0);
    chk({tag, " rlast"},   bus.rlast, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [63:0] first;
    int          n;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < NWORDS; i++) known[i] = 1'b0;

    tbl[0] = '{5'h0A, 32'h0000_0100, 8'd3, 2'b01, 8'hFF, 64'h1111_1111_1111_1111, 2'b00, 2'b01, 8'd3, 1};
    tbl[1] = '{5'h01, 32'h0000_0000, 8'd0, 2'b01, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 2'b01, 8'd0, -1};
    tbl[2] = '{5'h02, 32'h0000_0000, 8'd0, 2'b01, 8'h0F, 64'h0,                   2'b00, 2'b01, 8'd0, -1};
    tbl[3] = '{5'h03, 32'h0000_0040, 8'd1, 2'b01, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 2'b01, 8'd1, -1};
    tbl[4] = '{5'h04, 32'h0000_0040, 8'd1, 2'b10, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 2'b10, 2'b01, 8'd1, -1};
    tbl[5] = '{5'h05, 32'h0000_0080, 8'd2, 2'b00, 8'hFF, 64'h0102_0304_0506_0708, 2'b00, 2'b00, 8'd2, -1};
    tbl[6] = '{5'h06, 32'h0000_7FF0, 8'd3, 2'b01, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 2'b01, 8'd3, -1};
    tbl[7] = '{5'h07, 32'h0000_01FE, 8'd0, 2'b11, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 2'b10, 2'b01, 8'd0, -1};
    tbl[8] = '{5'h1F, 32'h8000_0108, 8'd1, 2'b01, 8'h81, 64'h1234_5678_90AB_CDEF, 2'b00, 2'b01, 8'd1, -1};
    tbl[9] = '{5'h08, 32'h0000_0110, 8'd0, 2'b01, 8'hFF, 64'hCAFE_F00D_CAFE_F00D, 2'b00, 2'b10, 8'd1, -1};

    // Reset state, during and just after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("after reset");
    @(posedge clk); #1;

    // Arbitration: read wins the first conflict, write wins the second.
    bus.awid = 5'h03; bus.awaddr = '0; bus.awlen = '0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.arid = 5'h04; bus.araddr = '0; bus.arlen = '0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("conflict1 arready", bus.arready, 1);
    chk("conflict1 awready", bus.awready, 0);
    @(posedge clk); #1 bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.rvalid && bus.rlast) && n < 20) begin @(negedge clk); n++; end
    chk("conflict1 read done", bus.rvalid, 1);
    @(posedge clk); #1 bus.rready = 1'b0;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("conflict2 awready", bus.awready, 1);
    chk("conflict2 arready", bus.arready, 0);
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = 8'h00; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.wready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    chk("conflict2 bvalid", bus.bvalid, 1);
    chk("conflict2 bresp", bus.bresp, 2'b00);
    chk("conflict2 bid", bus.bid, 5'h03);
    @(posedge clk); #1 bus.bready = 1'b0;

    // Fill words 0..63 so later reads have known contents.
    for (int i = 0; i < 64; i++) wbuf[i] = {$urandom, $urandom};
    do_write(5'h10, 32'h0, 8'd63, 2'b01, 8'hFF, -1, resp);
    chk("init bresp", resp, model_write(32'h0, 8'd63, 2'b01, 8'hFF));

    // Directed table.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i <= int'(tbl[t].len); i++) wbuf[i] = tbl[t].pat * 64'(i + 1);
      do_write(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].burst, tbl[t].strb, -1, resp);
      chk($sformatf("tbl%0d bresp", t), resp, tbl[t].exp_resp);
      void'(model_write(tbl[t].addr, tbl[t].len, tbl[t].burst, tbl[t].strb));
      do_read(tbl[t].id, tbl[t].addr, tbl[t].rd_len, tbl[t].rd_burst, tbl[t].stall, 3, 1'b0, first);
      if (t == 0) chk("tbl0 first beat", first, 64'h1111_1111_1111_1111);
      if (t == 2) chk("tbl2 strobe merge", first, 64'hFFFF_FFFF_0000_0000);
      if (t == 5) chk("tbl5 fixed beat", first, 64'h0306_090C_0F12_1518);
    end

    // wlast too early, then wlast missing on the final beat.
    wbuf[0] = 64'h1; wbuf[1] = 64'h2;
    do_write(5'h14, 32'h300, 8'd1, 2'b01, 8'hFF, 0, resp);
    chk("early wlast bresp", resp, 2'b10);
    do_write(5'h15, 32'h300, 8'd1, 2'b01, 8'hFF, 1, resp);
    chk("missing wlast bresp", resp, 2'b10);
    known[96] = 1'b0; known[97] = 1'b0;

    // Randomized bursts against the model.
    for (int it = 0; it < 30; it++) begin
      logic [31:0] addr = $urandom;
      logic [7:0]  len  = 8'($urandom_range(0, 7));
      logic [7:0]  strb = 8'($urandom);
      logic [4:0]  id   = 5'($urandom);
      int          sel  = int'($urandom_range(0, 9));
      logic [1:0]  burst = (sel < 6) ? 2'b01 : (sel < 9) ? 2'b00 : 2'b10;
      logic [1:0]  rburst = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      for (int i = 0; i <= int'(len); i++) wbuf[i] = {$urandom, $urandom};
      do_write(id, addr, len, burst, strb, -1, resp);
      chk("rand bresp", resp, model_write(addr, len, burst, strb));
      do_read(id, addr, 8'($urandom_range(0, 7)), rburst, -1, 0, 1'b1, first);
    end

    // Reset during beat 2 of a 4-beat read.
    bus.arid = 5'h09; bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.arvalid = 1'b0; bus.rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort beat2 rvalid", bus.rvalid, 1);
    chk("abort beat2 rlast", bus.rlast, 0);
    #2 rst_n = 1'b0; bus.rready = 1'b0;
    #1 chk_outputs_zero("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wbuf[0] = 64'h0123_4567_89AB_CDEF; wbuf[1] = 64'hFEDC_BA98_7654_3210;
    do_write(5'h0C, 32'h180, 8'd1, 2'b01, 8'hFF, -1, resp);
    chk("post reset bresp", resp, 2'b00);
    void'(model_write(32'h180, 8'd1, 2'b01, 8'hFF));
    do_read(5'h0D, 32'h180, 8'd1, 2'b01, -1, 0, 1'b0, first);
    chk("post reset first", first, 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
